// File: rtl/pair_compare_sequencer.sv
// rtl/pair_compare_sequencer.sv - serial two-bits-per-cycle magnitude comparator controller
// Walks operand pairs MSB first through a 4-bit comparator and stops at the first unequal pair.

module pair_comparator (
  input  logic [3:0] abcd_i,
  output logic [2:0] xyz_o
);
  always_comb begin
    if (abcd_i[3:2] > abcd_i[1:0])       xyz_o = 3'b100;
    else if (abcd_i[3:2] == abcd_i[1:0]) xyz_o = 3'b010;
    else                                 xyz_o = 3'b001;
  end
endmodule

module pair_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  input  logic                              start_i,
  input  logic [WIDTH-1:0]                  a_i,
  input  logic [WIDTH-1:0]                  b_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              greater_o,
  output logic                              equal_o,
  output logic                              less_o,
  output logic [$clog2(WIDTH/2+1)-1:0]      pairs_used_o
);
  localparam int NPAIRS = WIDTH / 2;
  localparam int PW     = $clog2(NPAIRS + 1);
  localparam int IW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             greater_q, greater_d, equal_q, equal_d, less_q, less_d;
  logic [PW-1:0]    used_q, used_d;
  logic [1:0]       a_pair, b_pair;
  logic [2:0]       xyz;

  // Pair mux written as a loop so the index never needs a width-cast multiply.
  always_comb begin
    a_pair = '0;
    b_pair = '0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (idx_q == IW'(i)) begin
        a_pair = a_q[2*i +: 2];
        b_pair = b_q[2*i +: 2];
      end
    end
  end

  pair_comparator u_cmp (
    .abcd_i ({a_pair, b_pair}),
    .xyz_o  (xyz)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    less_d    = less_q;
    used_d    = used_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d       = a_i;
          b_d       = b_i;
          idx_d     = IW'(NPAIRS - 1);
          greater_d = 1'b0;
          equal_d   = 1'b0;
          less_d    = 1'b0;
          used_d    = '0;
          state_d   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        used_d = used_q + PW'(1);
        case (xyz)
          3'b100: begin greater_d = 1'b1; state_d = S_DONE; end
          3'b001: begin less_d    = 1'b1; state_d = S_DONE; end
          // Anything not strictly greater/less counts as an equal pair.
          default: begin
            if (idx_q == '0) begin
              equal_d = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
      used_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      less_q    <= less_d;
      used_q    <= used_d;
    end
  end

  assign busy_o       = (state_q == S_COMPARE);
  assign done_o       = (state_q == S_DONE);
  assign greater_o    = greater_q;
  assign equal_o      = equal_q;
  assign less_o       = less_q;
  assign pairs_used_o = used_q;
endmodule

// File: tb/tb_pair_compare_sequencer.sv
// tb/tb_pair_compare_sequencer.sv - self-checking bench for pair_compare_sequencer
module tb_pair_compare_sequencer;
  localparam int WIDTH  = 8;
  localparam int NPAIRS = WIDTH / 2;
  localparam int PW     = $clog2(NPAIRS + 1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, greater, equal, less;
  logic [PW-1:0]    pairs_used;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pair_compare_sequencer #(.WIDTH(WIDTH)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .greater_o    (greater),
    .equal_o      (equal),
    .less_o       (less),
    .pairs_used_o (pairs_used)
  );

  // Reference: decision pair is the first differing 2-bit group from the MSB; result is plain magnitude order.
  function automatic void model(input int av, input int bv, output int k, output logic [2:0] gel);
    k = NPAIRS;
    for (int p = 1; p <= NPAIRS; p++) begin
      int sh;
      sh = 2 * (NPAIRS - p);
      if (((av >> sh) & 3) != ((bv >> sh) & 3)) begin
        k = p;
        break;
      end
    end
    gel = (av > bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
  endfunction

  // Presents operands with start and returns at the negedge just after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit keep_start);
    @(negedge clock);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clock);
    if (!keep_start) start = 1'b0;
  endtask

  // Observes the run until done; reports edges counted, busy cycles and whether results stayed clear while busy.
  task automatic collect(input bit scramble, output int lat, output int busy_cnt,
                         output bit timeout, output bit res_clean);
    lat = 0; busy_cnt = 0; timeout = 1'b1; res_clean = 1'b1;
    for (int i = 0; i < 4 * NPAIRS + 4; i++) begin
      if (busy) busy_cnt++;
      if (busy && (greater || equal || less || done)) res_clean = 1'b0;
      if (scramble) begin
        a = '1;
        b = '0;
      end
      @(negedge clock);
      lat++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit idle_ok;
    reset_n = 1'b0;
    start = 1'b1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, greater, equal, less} !== 5'b0 || pairs_used !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bdgel=%b pairs=%0d expected 00000 pairs=0",
               {busy, done, greater, equal, less}, pairs_used);
    end
    reset_n = 1'b1;
    start = 1'b0;
    idle_ok = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if ({busy, done, greater, equal, less} !== 5'b0 || pairs_used !== '0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL reset_idle: got activity without start expected idle outputs 0");
    end
  endtask

  task automatic test_equal();
    int lat, bc; bit to, clean;
    launch(8'h5A, 8'h5A, 1'b0);
    collect(1'b0, lat, bc, to, clean);
    checks++;
    if (to || lat != 4 || bc != 4 || !clean) begin
      errors++;
      $display("FAIL equal_timing: got timeout=%0d lat=%0d busy=%0d clean=%0d expected 0 4 4 1", to, lat, bc, clean);
    end
    checks++;
    if ({greater, equal, less} !== 3'b010 || pairs_used !== PW'(4)) begin
      errors++;
      $display("FAIL equal_result: got gel=%b pairs=%0d expected 010 pairs=4", {greater, equal, less}, pairs_used);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {greater, equal, less} !== 3'b010 || pairs_used !== PW'(4)) begin
      errors++;
      $display("FAIL equal_hold: got done=%b busy=%b gel=%b pairs=%0d expected 0 0 010 4",
               done, busy, {greater, equal, less}, pairs_used);
    end
  endtask

  task automatic test_greater_early();
    int lat, bc; bit to, clean;
    launch(8'h80, 8'h7F, 1'b0);
    collect(1'b0, lat, bc, to, clean);
    checks++;
    if (to || lat != 1 || bc != 1) begin
      errors++;
      $display("FAIL greater_timing: got timeout=%0d lat=%0d busy=%0d expected 0 1 1", to, lat, bc);
    end
    checks++;
    if ({greater, equal, less} !== 3'b100 || pairs_used !== PW'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL greater_result: got gel=%b pairs=%0d busy=%b expected 100 1 0",
               {greater, equal, less}, pairs_used, busy);
    end
    @(negedge clock);
  endtask

  task automatic test_less_changes();
    int lat, bc; bit to, clean;
    launch(8'h12, 8'h13, 1'b0);
    collect(1'b1, lat, bc, to, clean);
    checks++;
    if (to || lat != 4 || bc != 4 || !clean) begin
      errors++;
      $display("FAIL less_timing: got timeout=%0d lat=%0d busy=%0d clean=%0d expected 0 4 4 1", to, lat, bc, clean);
    end
    checks++;
    if ({greater, equal, less} !== 3'b001 || pairs_used !== PW'(4)) begin
      errors++;
      $display("FAIL less_result: got gel=%b pairs=%0d expected 001 pairs=4", {greater, equal, less}, pairs_used);
    end
    @(negedge clock);
  endtask

  task automatic test_start_while_busy();
    int lat, bc; bit to, clean;
    launch(8'h12, 8'h13, 1'b1);
    collect(1'b0, lat, bc, to, clean);
    checks++;
    if (to || lat != 4 || {greater, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL busy_start_first: got timeout=%0d lat=%0d gel=%b expected 0 4 001", to, lat, {greater, equal, less});
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || less !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_idle: got done=%b busy=%b less=%b expected 0 0 1", done, busy, less);
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || {greater, equal, less} !== 3'b000 || pairs_used !== '0) begin
      errors++;
      $display("FAIL busy_start_accept: got busy=%b gel=%b pairs=%0d expected 1 000 0",
               busy, {greater, equal, less}, pairs_used);
    end
    collect(1'b0, lat, bc, to, clean);
    checks++;
    if (to || lat != 4 || {greater, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL busy_start_second: got timeout=%0d lat=%0d gel=%b expected 0 4 001", to, lat, {greater, equal, less});
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit to, clean; bit saw_done;
    launch(8'h12, 8'h13, 1'b0);
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, greater, equal, less} !== 5'b0 || pairs_used !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got bdgel=%b pairs=%0d expected 00000 0",
               {busy, done, greater, equal, less}, pairs_used);
    end
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (NPAIRS + 2) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_resume: got activity after reset expected none");
    end
    launch(8'h12, 8'h13, 1'b0);
    collect(1'b0, lat, bc, to, clean);
    checks++;
    if (to || lat != 4 || bc != 4 || {greater, equal, less} !== 3'b001 || pairs_used !== PW'(4)) begin
      errors++;
      $display("FAIL reset_mid_fresh: got timeout=%0d lat=%0d busy=%0d gel=%b pairs=%0d expected 0 4 4 001 4",
               to, lat, bc, {greater, equal, less}, pairs_used);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int lat, bc, k; bit to, clean; logic [2:0] gel;
    logic [WIDTH-1:0] av, bv, mask;
    for (int n = 0; n < 40; n++) begin
      av = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: bv = av;
        1: begin
          mask = WIDTH'({WIDTH{1'b1}} << (2 * $urandom_range(0, NPAIRS - 1)));
          bv = (av & mask) | (WIDTH'($urandom) & ~mask);
        end
        default: bv = WIDTH'($urandom);
      endcase
      model(int'(av), int'(bv), k, gel);
      launch(av, bv, 1'b0);
      collect($urandom_range(0, 1) == 1, lat, bc, to, clean);
      checks++;
      if (to || lat != k || bc != k || !clean || {greater, equal, less} !== gel || pairs_used !== PW'(k)) begin
        errors++;
        $display("FAIL random a=%h b=%h: got timeout=%0d lat=%0d busy=%0d clean=%0d gel=%b pairs=%0d expected lat=%0d gel=%b pairs=%0d",
                 av, bv, to, lat, bc, clean, {greater, equal, less}, pairs_used, k, gel, k);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || {greater, equal, less} !== gel) begin
        errors++;
        $display("FAIL random_hold a=%h b=%h: got done=%b gel=%b expected 0 %b", av, bv, done, {greater, equal, less}, gel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_greater_early();
    test_less_changes();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pair_compare_sequencer.md
# pair_compare_sequencer

Serial magnitude comparator controller. It compares two WIDTH-bit unsigned operands two bits at a time, MSB pair first, through one instance of the team's 4-bit comparator (input abcd = {a-pair, b-pair}, one-hot output xyz = greater/equal/less). It sits between a requester using a start/done handshake and the shared comparator datapath. It sequences the pairs, stops at the first unequal pair, and holds a registered one-hot result.

## Interface
- WIDTH, default 8: operand width in bits. Must be even and ≥ 2. NPAIRS = WIDTH/2.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a comparison; sampled only in IDLE.
- a  in  WIDTH  operand A, unsigned; captured when start is accepted.
- b  in  WIDTH  operand B, unsigned; captured when start is accepted.
- busy  out  1  high while in COMPARE.
- done  out  1  single-cycle pulse, high for the one cycle spent in DONE.
- greater  out  1  registered result, A > B.
- equal  out  1  registered result, A == B.
- less  out  1  registered result, A < B.
- pairs_used  out  $clog2(NPAIRS+1)  number of pairs examined by the last comparison.

## Operation
- States: IDLE, COMPARE, DONE. State encoding is free.
- **Reset (asynchronous, reset_n=0):**
  - state goes to IDLE.
  - busy, done, greater, equal, less and pairs_used go to 0.
  - operand registers and the pair index are cleared.
  - This applies at any time, including mid-COMPARE, and nothing is resumed afterwards.
- **IDLE:**
  - If start=1: capture a and b into operand registers, set index = NPAIRS-1, clear greater/equal/less/pairs_used to 0, and go to COMPARE.
  - Otherwise stay in IDLE.
- **COMPARE:**
  - Comparator input is combinational: abcd = {A[2i+1:2i], B[2i+1:2i]}, where i = index.
  - On each edge, pairs_used increments by 1.
  - If xyz=100: set greater=1 and go to DONE.
  - If xyz=001: set less=1 and go to DONE.
  - If xyz=010 and index=0: set equal=1 and go to DONE.
  - If xyz=010 and index>0: decrement index and stay in COMPARE.
  - Any other xyz value (not one-hot) is treated as 010. The comparator cannot produce one.
- **DONE:**
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE.
- Result outputs and pairs_used hold their values from DONE until the next accepted start.
- After a completed comparison, exactly one of greater/equal/less is 1. All three are 0 after reset and during COMPARE.
- start is ignored while busy. Operand inputs are don't-care outside the accepting edge; later changes have no effect.
- pairs_used range is 1..NPAIRS and never wraps, because the index stops at 0.

## Timing
- Start is accepted at rising edge E0. busy=1 from E0 until the deciding edge.
- Pair k (k=1..NPAIRS, counting from MSB) is evaluated in the cycle between edges E(k-1) and Ek.
- If the decision falls on pair k: results, pairs_used=k and done=1 become visible after Ek, busy=0 after Ek, and done=0 after E(k+1).
- Latency from start to done is k cycles: minimum 1, maximum NPAIRS.
- Back-to-back throughput: the next start is accepted no earlier than edge E(k+2). One IDLE cycle is mandatory after DONE.
- There is no combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset:** reset_n=0 with arbitrary inputs, then release -> busy=done=greater=equal=less=0, pairs_used=0, and the block stays idle without start.
- **Equal operands:** WIDTH=8, a=0x5A, b=0x5A, start for one cycle -> busy for 4 cycles, done pulse after E4, equal=1, greater=less=0, pairs_used=4.
- **Early exit on greater:** a=0x80, b=0x7F -> MSB pair 10 vs 01, done after E1, greater=1, pairs_used=1, busy for 1 cycle.
- **Late decision on less, with input changes:** a=0x12, b=0x13 -> less=1, pairs_used=4, done after E4. Changing a/b to 0xFF/0x00 during COMPARE does not change the result.
- **start while busy:** start held high throughout the 0x12/0x13 comparison -> only one done pulse in DONE, one IDLE cycle, then a new comparison is accepted. Results clear to 0 at that acceptance.
- **Reset mid-operation:** reset_n pulsed low after E2 of a 0x12/0x13 comparison -> outputs go to 0 immediately, no done pulse, and the next start performs a full fresh comparison.
